// File: rtl/dca_matrix_lsu_row_scatter.sv
// -----------------------------------------------------------------------------
// dca_matrix_lsu_row_scatter
//
// Takes one memory-row-buffer word at a time and returns a run of
// AXI-data-width lanes from it as R beats. The run starts at the lane that
// holds the supplied bit address and wraps around the row. rlast is raised
// only on the final beat of a row that closes its transaction. A new row may
// be accepted on the same edge that retires the final beat of the current
// row, so back-to-back rows stream without a bubble.
// -----------------------------------------------------------------------------
module dca_matrix_lsu_row_scatter #(
    parameter  int BW_MEMORY_ROW_BUFFER = 256,
    parameter  int BW_AXI_DATA          = 32,
    localparam int NUM_LANE             = BW_MEMORY_ROW_BUFFER / BW_AXI_DATA,
    localparam int BW_LANE_IDX          = $clog2(NUM_LANE),
    localparam int BW_BITADDR           = $clog2(BW_MEMORY_ROW_BUFFER),
    localparam int BW_ROW_INFO          = 2 + BW_LANE_IDX + BW_BITADDR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic [BW_MEMORY_ROW_BUFFER-1:0] row_data,
    input  logic [BW_ROW_INFO-1:0]          row_info,
    output logic                            rvalid,
    input  logic                            rready,
    output logic [BW_AXI_DATA-1:0]          rdata,
    output logic [1:0]                      rresp,
    output logic                            rlast
);

    // Bit addresses below one lane are dropped: this many low bits.
    localparam int BW_LANE_OFS = BW_BITADDR - BW_LANE_IDX;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Row buffer viewed as lanes so the beat mux is a plain index.
    logic [NUM_LANE-1:0][BW_AXI_DATA-1:0] row_buf_q;
    logic [BW_LANE_IDX-1:0]               ptr_q;
    logic [BW_LANE_IDX-1:0]               cnt_q;
    logic                                 err_q;
    logic                                 txn_last_q;

    // Unpacked view of row_info {err, txn_last, num_beat_m1, bitaddr}.
    logic                   info_err;
    logic                   info_txn_last;
    logic [BW_LANE_IDX-1:0] info_num_beat_m1;
    logic [BW_LANE_IDX-1:0] info_lane;
    logic                   unused_bitaddr_lsb;

    logic row_fire;
    logic beat_fire;
    logic final_beat;

    assign info_err           = row_info[BW_ROW_INFO-1];
    assign info_txn_last      = row_info[BW_ROW_INFO-2];
    assign info_num_beat_m1   = row_info[BW_BITADDR +: BW_LANE_IDX];
    assign info_lane          = row_info[BW_BITADDR-1 -: BW_LANE_IDX];
    assign unused_bitaddr_lsb = ^row_info[BW_LANE_OFS-1:0];

    assign rvalid     = (state_q == ST_BUSY);
    assign final_beat = (cnt_q == '0);
    assign beat_fire  = rvalid & rready;
    assign row_fire   = row_valid & row_ready;

    // A row can only enter when the buffer is free or is being emptied by the
    // final beat on this very edge; reset holds the input closed.
    assign row_ready = ~rst & (~rvalid | (rready & final_beat));

    assign rdata = row_buf_q[ptr_q];
    assign rresp = err_q ? 2'b10 : 2'b00;
    assign rlast = rvalid & txn_last_q & final_beat;

    // State register: reset drops rvalid immediately, discarding any row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update together from pre-edge values, whatever the order here.
            state_q <= state_d;
        end
    end

    // Next state: go busy on a row, fall empty after a final beat with no
    // replacement row arriving on the same edge.
    always_comb begin
        // NOTE: the default comes first so every path assigns state_d and no
        // latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (row_fire) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat_fire && final_beat) begin
                    state_d = row_fire ? ST_BUSY : ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Row buffer, lane pointer, beat counter and flags: load on accept,
    // advance on a non-final beat, otherwise hold (this also keeps the beat
    // stable under backpressure).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the row buffer is reset on purpose so rdata reads zero
            // during and after reset instead of a stale row.
            row_buf_q  <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            txn_last_q <= 1'b0;
        end else if (row_fire) begin
            row_buf_q  <= row_data;
            ptr_q      <= info_lane;
            cnt_q      <= info_num_beat_m1;
            err_q      <= info_err;
            txn_last_q <= info_txn_last;
        end else if (beat_fire && !final_beat) begin
            // Lane count is a power of two, so the natural wrap is modulo.
            ptr_q <= ptr_q + BW_LANE_IDX'(1);
            cnt_q <= cnt_q - BW_LANE_IDX'(1);
        end
    end

endmodule

// File: tb/tb_dca_matrix_lsu_row_scatter.sv
// -----------------------------------------------------------------------------
// Bench for dca_matrix_lsu_row_scatter. Accepted rows push their expected
// beats into a scoreboard queue; each taken beat pops and compares. A table of
// single-row vectors runs in a loop, followed by hand-written back-to-back,
// backpressure and mid-row reset sequences.
// -----------------------------------------------------------------------------
module tb_dca_matrix_lsu_row_scatter;

    localparam int BW_ROW = 256;
    localparam int BW_AXI = 32;
    localparam int NLANE  = BW_ROW / BW_AXI;
    localparam int BW_INFO = 2 + 3 + 8;

    typedef struct {
        logic        err;
        logic        txn_last;
        logic [2:0]  nb_m1;
        logic [7:0]  bitaddr;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic                clk;
    logic                rst;
    logic                row_valid;
    logic                row_ready;
    logic [BW_ROW-1:0]   row_data;
    logic [BW_INFO-1:0]  row_info;
    logic                rvalid;
    logic                rready;
    logic [BW_AXI-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;

    int total = 0;
    int bad   = 0;

    beat_t sb[$];

    // Per-cycle samples and per-row statistics.
    logic        s_rvalid;
    logic        s_row_ready;
    int          n_taken;
    int          rlast_cnt;
    logic [31:0] first_data;
    logic [31:0] last_data;
    logic        hold_pending;
    logic [31:0] held_data;
    logic [1:0]  held_resp;
    logic        held_last;

    dca_matrix_lsu_row_scatter #(
        .BW_MEMORY_ROW_BUFFER(BW_ROW),
        .BW_AXI_DATA         (BW_AXI)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_data (row_data),
        .row_info (row_info),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW_INFO-1:0] mk_info(input logic err, input logic last,
                                                   input logic [2:0] nb, input logic [7:0] ba);
        return {err, last, nb, ba};
    endfunction

    // Model: beats of a row are lanes bitaddr/32, +1, ... modulo 8.
    task automatic push_row(input logic [BW_ROW-1:0] data, input logic [BW_INFO-1:0] info);
        beat_t      b;
        logic [2:0] lane;
        logic [2:0] nb;
        nb = info[10:8];
        for (int i = 0; i <= int'(nb); i++) begin
            lane   = info[7:5] + 3'(i);
            b.data = data[int'(lane)*BW_AXI +: BW_AXI];
            b.resp = info[12] ? 2'b10 : 2'b00;
            b.last = info[11] && (i == int'(nb));
            sb.push_back(b);
        end
    endtask

    task automatic clear_stats();
        n_taken   = 0;
        rlast_cnt = 0;
        first_data = '0;
        last_data  = '0;
    endtask

    // One clock cycle, entered and left at the falling edge. Inputs are
    // applied, outputs sampled 1ns later, then the rising edge passes.
    task automatic cycle(input logic rv, input logic [BW_INFO-1:0] info, input logic rr);
        beat_t e;
        row_valid = rv;
        row_info  = info;
        rready    = rr;
        #1;
        s_rvalid    = rvalid;
        s_row_ready = row_ready;
        if (hold_pending) begin
            check("hold_rvalid", 32'(rvalid), 32'd1);
            check("hold_rdata", rdata, held_data);
            check("hold_rresp", 32'(rresp), 32'(held_resp));
            check("hold_rlast", 32'(rlast), 32'(held_last));
            hold_pending = 1'b0;
        end
        if (rvalid && !rr) begin
            hold_pending = 1'b1;
            held_data    = rdata;
            held_resp    = rresp;
            held_last    = rlast;
        end
        if (rvalid && rr) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %0h want no beat", rdata);
            end else begin
                e = sb.pop_front();
                check("beat_data", rdata, e.data);
                check("beat_resp", 32'(rresp), 32'(e.resp));
                check("beat_last", 32'(rlast), 32'(e.last));
            end
            n_taken++;
            if (n_taken == 1) first_data = rdata;
            last_data = rdata;
            if (rlast) rlast_cnt++;
        end
        if (rv && row_ready) push_row(row_data, info);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle with rready high until the DUT and scoreboard are empty.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((rvalid || sb.size() != 0) && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        if (rvalid || sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending want 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[5];
    logic exp_rr_bp[5];

    initial begin
        // lane i = i
        for (int i = 0; i < NLANE; i++) row_data[i*BW_AXI +: BW_AXI] = 32'(i);
        rst = 1'b1;
        row_valid = 1'b0;
        row_info  = '0;
        rready    = 1'b0;
        hold_pending = 1'b0;
        clear_stats();

        vecs[0] = '{err: 1'b0, txn_last: 1'b1, nb_m1: 3'd3, bitaddr: 8'd64,  exp_first: 32'h2, exp_last: 32'h5};
        vecs[1] = '{err: 1'b0, txn_last: 1'b1, nb_m1: 3'd3, bitaddr: 8'd192, exp_first: 32'h6, exp_last: 32'h1};
        vecs[2] = '{err: 1'b0, txn_last: 1'b1, nb_m1: 3'd0, bitaddr: 8'd37,  exp_first: 32'h1, exp_last: 32'h1};
        vecs[3] = '{err: 1'b1, txn_last: 1'b1, nb_m1: 3'd7, bitaddr: 8'd0,   exp_first: 32'h0, exp_last: 32'h7};
        vecs[4] = '{err: 1'b0, txn_last: 1'b0, nb_m1: 3'd2, bitaddr: 8'd250, exp_first: 32'h7, exp_last: 32'h1};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_row_ready", 32'(row_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_row_ready", 32'(row_ready), 32'd1);
        @(negedge clk);

        // Table of single rows with rready held high.
        for (int v = 0; v < 5; v++) begin
            clear_stats();
            cycle(1'b1, mk_info(vecs[v].err, vecs[v].txn_last, vecs[v].nb_m1, vecs[v].bitaddr), 1'b1);
            check("vec_accept", 32'(s_row_ready), 32'd1);
            drain(20);
            check("vec_count", 32'(n_taken), 32'(int'(vecs[v].nb_m1) + 1));
            check("vec_first", first_data, vecs[v].exp_first);
            check("vec_last", last_data, vecs[v].exp_last);
            check("vec_rlast_cnt", 32'(rlast_cnt), 32'(vecs[v].txn_last));
        end

        // Back-to-back: A (2 beats, no rlast) then B (1 beat, SLVERR, rlast).
        clear_stats();
        cycle(1'b1, mk_info(1'b0, 1'b0, 3'd1, 8'd0), 1'b1);
        cycle(1'b1, mk_info(1'b1, 1'b1, 3'd0, 8'd224), 1'b1);
        check("b2b_rv1", 32'(s_rvalid), 32'd1);
        check("b2b_rr1", 32'(s_row_ready), 32'd0);
        cycle(1'b1, mk_info(1'b1, 1'b1, 3'd0, 8'd224), 1'b1);
        check("b2b_rv2", 32'(s_rvalid), 32'd1);
        check("b2b_rr2", 32'(s_row_ready), 32'd1);
        cycle(1'b0, '0, 1'b1);
        check("b2b_rv3", 32'(s_rvalid), 32'd1);
        check("b2b_last_data", last_data, 32'h7);
        check("b2b_count", 32'(n_taken), 32'd3);
        check("b2b_rlast_cnt", 32'(rlast_cnt), 32'd1);
        drain(10);

        // Backpressure: rready 1,0,0,1,1 over lanes 1,2,3.
        exp_rr_bp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_stats();
        cycle(1'b1, mk_info(1'b0, 1'b1, 3'd2, 8'd32), 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("bp_rr0", 32'(s_row_ready), 32'(exp_rr_bp[0]));
        check("bp_first", first_data, 32'h1);
        cycle(1'b0, '0, 1'b0);
        check("bp_rr1", 32'(s_row_ready), 32'(exp_rr_bp[1]));
        cycle(1'b0, '0, 1'b0);
        check("bp_rr2", 32'(s_row_ready), 32'(exp_rr_bp[2]));
        cycle(1'b0, '0, 1'b1);
        check("bp_rr3", 32'(s_row_ready), 32'(exp_rr_bp[3]));
        check("bp_second", last_data, 32'h2);
        cycle(1'b0, '0, 1'b1);
        check("bp_rr4", 32'(s_row_ready), 32'(exp_rr_bp[4]));
        check("bp_third", last_data, 32'h3);
        check("bp_rlast_cnt", 32'(rlast_cnt), 32'd1);
        drain(10);

        // Reset mid-row: lanes 0..3, reset after the second beat.
        clear_stats();
        cycle(1'b1, mk_info(1'b0, 1'b1, 3'd3, 8'd0), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("mid_taken", 32'(n_taken), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rvalid", 32'(rvalid), 32'd0);
        check("mid_rdata", rdata, 32'd0);
        check("mid_rlast", 32'(rlast), 32'd0);
        check("mid_row_ready", 32'(row_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_ready", 32'(row_ready), 32'd1);
        @(negedge clk);
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1);
            check("mid_no_stale", 32'(s_rvalid), 32'd0);
        end
        cycle(1'b1, mk_info(1'b0, 1'b1, 3'd0, 8'd96), 1'b1);
        drain(10);
        check("mid_new_count", 32'(n_taken), 32'd1);
        check("mid_new_data", first_data, 32'h3);
        check("mid_new_rlast", 32'(rlast_cnt), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound in case a wait above never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
